// File: rtl/int_to_float.sv
// Purpose: iterative 32-bit integer (signed or unsigned) to IEEE-754 single conversion.
// Latency: 3 + leading-zero count of the magnitude (3..34 cycles), zero operand 1 cycle.
// Backpressure: accepts one operand at a time in IDLE; holds the result in DONE until out_ready.
//
// Ports:
//   CLK, RESET          clock and synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready only while idle)
//   int_operand         integer source, is_unsigned selects FCVT.S.WU vs FCVT.S.W
//   result, fflag_nx    single-precision result and inexact flag
//   out_valid/out_ready result handshake
module int_to_float (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] int_operand,
  input  logic        is_unsigned,
  output logic [31:0] result,
  output logic        fflag_nx,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q;
  logic        sign_q;
  logic [31:0] mag_q;
  logic [7:0]  exp_q;
  logic [31:0] result_q;
  logic        nx_q;
  logic        out_valid_q;

  // Operand decode at accept time.
  logic        sign_d;
  logic [31:0] mag_d;

  always_comb begin
    sign_d = ~is_unsigned & int_operand[31];
    // Negating 0x80000000 wraps back to 0x80000000, which is the correct magnitude.
    mag_d  = sign_d ? (~int_operand + 32'd1) : int_operand;
  end

  // Rounding datapath, only meaningful while in ROUND (mag_q[31] is set there).
  logic [22:0] mant_w;
  logic        guard_w;
  logic        sticky_w;
  logic        round_up_w;
  logic [23:0] mant_inc_w;
  logic [22:0] mant_d;
  logic [7:0]  exp_d;

  always_comb begin
    mant_w     = mag_q[30:8];
    guard_w    = mag_q[7];
    sticky_w   = |mag_q[6:0];
    round_up_w = guard_w & (sticky_w | mant_w[0]);
    mant_inc_w = {1'b0, mant_w} + 24'd1;
    mant_d     = mant_w;
    exp_d      = exp_q;
    if (round_up_w) begin
      if (mant_inc_w[23]) begin
        // Mantissa wrapped: value is exactly the next power of two.
        mant_d = 23'd0;
        exp_d  = exp_q + 8'd1;
      end else begin
        mant_d = mant_inc_w[22:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= 32'd0;
      exp_q       <= 8'd0;
      result_q    <= 32'd0;
      nx_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q <= sign_d;
            mag_q  <= mag_d;
            if (mag_d == 32'd0) begin
              result_q    <= 32'd0;
              nx_q        <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              // 158 = bias 127 + 31: exponent of a value whose MSB sits at bit 31.
              exp_q   <= 8'd158;
              state_q <= NORM;
            end
          end
        end
        NORM: begin
          if (mag_q[31]) begin
            state_q <= ROUND;
          end else begin
            mag_q <= {mag_q[30:0], 1'b0};
            exp_q <= exp_q - 8'd1;
          end
        end
        ROUND: begin
          result_q    <= {sign_q, exp_d, mant_d};
          nx_q        <= guard_w | sticky_w;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign result    = result_q;
  assign fflag_nx  = nx_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/int_to_float.md
INT_TO_FLOAT -- requirements
Module: int_to_float

Interface
REQ-001 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-003 SHALL have port in_valid  input  1  operand offered.
REQ-004 SHALL have port in_ready  output  1  block can accept operand.
REQ-005 SHALL have port int_operand  input  32  integer source (FCVT.S.W / FCVT.S.WU).
REQ-006 SHALL have port is_unsigned  input  1  1 = treat int_operand as unsigned; sampled with int_operand.
REQ-007 SHALL have port result  output  32  IEEE-754 single-precision result.
REQ-008 SHALL have port fflag_nx  output  1  inexact flag for result.
REQ-009 SHALL have port out_valid  output  1  result and fflag_nx valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.

Function
REQ-011 SHALL use a state machine with states IDLE, NORM, ROUND, DONE.
REQ-012 SHALL assert in_ready only in IDLE; accept occurs on the edge where in_valid & in_ready.
REQ-013 On accept, SHALL register sign = ~is_unsigned & int_operand[31] and a 32-bit magnitude mag = sign ? two's-complement negation : int_operand; 0x80000000 signed gives mag 0x80000000.
REQ-014 On accept with mag == 0, SHALL go directly to DONE with result 0x00000000 and fflag_nx 0.
REQ-015 On accept with mag != 0, SHALL load exp = 158 and enter NORM.
REQ-016 In NORM, if mag[31] == 0, SHALL shift mag left 1 and decrement exp by 1 in that cycle; if mag[31] == 1, SHALL go to ROUND with no shift.
REQ-017 In ROUND: mant = mag[30:8], guard = mag[7], sticky = OR of mag[6:0].
REQ-018 SHALL round to nearest, ties to even: increment mant when guard & (sticky | mant[0]).
REQ-019 On mant increment overflow (all ones), SHALL set mant to 0 and exp + 1; exp never exceeds 159, so no infinity path.
REQ-020 In ROUND, SHALL register result = {sign, exp[7:0], mant} and fflag_nx = guard | sticky, then enter DONE.
REQ-021 In DONE, SHALL hold out_valid = 1; result and fflag_nx SHALL stay stable until out_ready is sampled high.
REQ-022 On DONE & out_ready, SHALL go to IDLE and deassert out_valid next cycle; no new operand is accepted in that same cycle.
REQ-023 Latency: with accept edge ending cycle T and lz = leading zeros of mag, out_valid first high in cycle T+3+lz (T+3..T+34); zero operand gives T+1.
REQ-024 SHALL ignore in_valid, int_operand and is_unsigned outside IDLE.
REQ-025 With out_ready held high, SHALL accept the next operand one cycle after DONE exits (throughput = latency + 1).

Reset
REQ-026 While RESET is high at a clock edge, SHALL enter IDLE with result = 0, fflag_nx = 0, out_valid = 0; in_ready SHALL be 1 from the following cycle.
REQ-027 RESET SHALL abort any in-flight conversion in NORM, ROUND or DONE; no out_valid pulse SHALL follow from the aborted operand.
REQ-028 RESET SHALL take priority over accept and over out_ready in the same cycle.

Verification
REQ-029 Signed 1 -> result 0x3F800000, nx 0, out_valid at T+34; signed -1 -> 0xBF800000.
REQ-030 Signed 0x80000000 -> 0xCF000000 at T+3; same value unsigned -> 0x4F000000.
REQ-031 Unsigned 0xFFFFFFFF -> 0x4F800000 (mantissa carry into exponent), nx 1; signed 0x01000001 -> 0x4B800000 (tie to even), nx 1, T+10.
REQ-032 Zero -> 0x00000000, nx 0, out_valid at T+1; signed 0x7FFFFFFF -> 0x4F000000, nx 1.
REQ-033 Hold out_ready low 5 cycles in DONE: result, nx and out_valid stable; in_ready stays 0; exactly one transfer on release.
REQ-034 Assert RESET during NORM of signed 1: next cycle out_valid 0, result 0, in_ready 1; a following operand of 3.0 (0x00000003) -> 0x40400000.
